uart_tx_scheduler: RTL and testbench
====================================

# uart_tx_scheduler

Round-robin scheduler that shares the single 7-bit `uart_tx` transmitter among `NUM_REQ` requesters. Sits directly in front of `uart_tx` in the `baud_clk` domain. It arbitrates pending bytes, honours the `cts`/`rts` flow control, and launches one frame at a time. It then waits for the transmitter to finish and for an inter-frame guard gap before serving the next requester.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 7: character width; must match `uart_tx` `data_in`.
- `START_TO`, 4: cycles allowed for `tx_buffer_empty` to fall after `tx_start`.
- `GAP`, 2: idle guard cycles after a frame completes, 0..15.

Ports:
- `baud_clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NUM_REQ  per-requester "byte pending".
- `req_data`  in  NUM_REQ*DATA_W  requester i's byte in bits [i*DATA_W +: DATA_W].
- `grant_ack`  out  NUM_REQ  one-hot, one-cycle pulse: requester's byte accepted by transmitter.
- `tx_data`  out  DATA_W  byte to `uart_tx` `data_in`; held stable from LAUNCH until return to IDLE.
- `tx_start`  out  1  one-cycle launch pulse to `uart_tx` `tx`.
- `tx_buffer_empty`  in  1  from `uart_tx`; 1 = transmitter idle.
- `cts`  in  1  far end clear-to-send; 1 = allowed.
- `rts`  out  1  registered; 1 when any `req` bit was high last cycle.
- `active_id`  out  $clog2(NUM_REQ)  index of current/last granted requester.
- `busy`  out  1  1 in any state other than IDLE.
- `start_err`  out  1  sticky; set on start timeout, cleared only by `rst`.

## Operation
- States: IDLE, LAUNCH, WAIT_START, WAIT_DONE, GUARD.
- IDLE: when `|req && cts && tx_buffer_empty`, pick a winner and go to LAUNCH.
  - Winner is the first set `req` bit searching upward, modulo NUM_REQ, from `ptr+1`.
  - On the same edge, latch `req_data` of the winner into `tx_data` and the winner into `active_id`.
  - Otherwise stay in IDLE.
- LAUNCH: `tx_start`=1 for exactly this cycle; go to WAIT_START with timeout counter = 0.
- WAIT_START:
  - `tx_buffer_empty`==0: pulse `grant_ack[active_id]`, set `ptr` = `active_id`, go to WAIT_DONE.
  - Otherwise increment the counter. When it reaches START_TO, set `start_err`, go to IDLE with no ack and `ptr` unchanged, so the same requester wins the retry.
- WAIT_DONE: wait for `tx_buffer_empty`==1, then go to GUARD with gap counter = 0. If GAP==0, go straight to IDLE.
- GUARD: count GAP cycles, then IDLE.
- `ptr` resets to NUM_REQ-1, so requester 0 has first priority after reset.
- `cts` is sampled only in IDLE. Deassertion mid-frame does not abort the frame in flight.
- Requester contract:
  - Hold `req` and data until `grant_ack`.
  - Data is latched at grant, so it may change freely after the IDLE→LAUNCH edge.
  - If `req` drops after the grant decision, the latched byte is still sent and still acked.
  - Deassert `req` in the cycle after `grant_ack` unless another byte is pending.

## Timing
- Reset values: `grant_ack`=0, `tx_start`=0, `tx_data`=0, `rts`=0, `active_id`=0, `busy`=0, `start_err`=0; state IDLE.
- All outputs are registered or decoded from state registers; there is no combinational path from inputs to outputs.
- Request sampled at edge k (IDLE) → `tx_start` high in cycle k+1 → earliest `grant_ack` in cycle k+2. This assumes `uart_tx` drops `tx_buffer_empty` one edge after `tx_start`.
- Back-to-back throughput: one frame per (frame length + GAP + 3) cycles minimum.
- `rst` asserted in any state → IDLE on the next edge. No ack is issued and the pending requester must re-present its byte.
- Simultaneous `tx_buffer_empty` rise and a new `req` in WAIT_DONE: the new request is not served until IDLE after GUARD.

## Test plan
- Single request: `req`=4'b0001, `req_data[6:0]`=7'h55, `cts`=1.
  - Expect `tx_start` one cycle later with `tx_data`=7'h55.
  - Expect `grant_ack`=4'b0001 once `tx_buffer_empty` falls, then `busy` low GAP cycles after the frame ends.
- Fairness: `req`=4'b1111 held, with data 7'h10..7'h13.
  - Grant order must be 0,1,2,3,0, with exactly one `grant_ack` per frame.
- Flow control: `cts`=0 with `req`=4'b0100.
  - Expect `rts`=1 and no `tx_start` for 20 cycles; raise `cts` and expect launch of requester 2 within 2 cycles.
  - Drop `cts` mid-frame: the frame completes normally.
- Start timeout: transmitter model never drops `tx_buffer_empty`, `req`=4'b0010.
  - After START_TO cycles, `start_err`=1 with no ack; the next launch is requester 1 again.
- Reset mid-frame: assert `rst` in WAIT_DONE.
  - Next cycle: `busy`=0, `start_err`=0, all outputs at reset values.
  - With `req`=4'b1000 asserted after reset, requester 3 is granted correctly (ptr reset to 3, search starts at 0).

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one uart_tx transmitter among NUM_REQ requesters.
// Launches one frame at a time, waits for completion, then a guard gap.
module uart_tx_scheduler #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 7,
    parameter int START_TO = 4,
    parameter int GAP      = 2
) (
    input  logic                        baud_clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          grant_ack,
    output logic [DATA_W-1:0]           tx_data,
    output logic                        tx_start,
    input  logic                        tx_buffer_empty,
    input  logic                        cts,
    output logic                        rts,
    output logic [$clog2(NUM_REQ)-1:0]  active_id,
    output logic                        busy,
    output logic                        start_err,
    output logic [2:0]                  state_dbg
);
    localparam int ID_W     = $clog2(NUM_REQ);
    localparam int CNT_MAX  = (START_TO > GAP) ? START_TO : GAP;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_LAUNCH     = 3'd1;
    localparam logic [2:0] S_WAIT_START = 3'd2;
    localparam logic [2:0] S_WAIT_DONE  = 3'd3;
    localparam logic [2:0] S_GUARD      = 3'd4;

    // Handshake: a requester holds req (valid) and its byte until grant_ack
    // pulses for one cycle; that pulse is the only point a byte counts as taken.
    logic [2:0]         state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    active_id_q, active_id_d;
    logic [DATA_W-1:0]  tx_data_q, tx_data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic               start_err_q, start_err_d;
    logic               rts_q, rts_d;
    logic [NUM_REQ-1:0] grant_ack_q, grant_ack_d;

    logic [ID_W-1:0]    win_id;
    logic               win_found;
    logic [ID_W:0]      cand;

    assign cnt_inc = cnt_q + 1'b1;

    // Search upward from ptr+1, wrapping at NUM_REQ; first pending bit wins.
    always_comb begin
        win_id    = ptr_q;
        win_found = 1'b0;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = {1'b0, ptr_q} + (ID_W+1)'(i);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!win_found && req[cand[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_id    = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        active_id_d = active_id_q;
        tx_data_d   = tx_data_q;
        cnt_d       = cnt_q;
        start_err_d = start_err_q;
        grant_ack_d = '0;
        rts_d       = |req;
        case (state_q)
            S_IDLE: begin
                if (|req && cts && tx_buffer_empty) begin
                    state_d     = S_LAUNCH;
                    active_id_d = win_id;
                    tx_data_d   = req_data[win_id*DATA_W +: DATA_W];
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT_START;
                cnt_d   = '0;
            end
            S_WAIT_START: begin
                if (!tx_buffer_empty) begin
                    grant_ack_d = NUM_REQ'(1) << active_id_q;
                    ptr_d       = active_id_q;
                    state_d     = S_WAIT_DONE;
                end else begin
                    // Timeout leaves ptr alone so the same requester retries first.
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(START_TO)) begin
                        start_err_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (tx_buffer_empty) begin
                    cnt_d   = '0;
                    state_d = (GAP == 0) ? S_IDLE : S_GUARD;
                end
            end
            S_GUARD: begin
                if (cnt_q == CNT_W'(GAP_LAST)) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge baud_clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= ID_W'(NUM_REQ - 1);
            active_id_q <= '0;
            tx_data_q   <= '0;
            cnt_q       <= '0;
            start_err_q <= 1'b0;
            rts_q       <= 1'b0;
            grant_ack_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            active_id_q <= active_id_d;
            tx_data_q   <= tx_data_d;
            cnt_q       <= cnt_d;
            start_err_q <= start_err_d;
            rts_q       <= rts_d;
            grant_ack_q <= grant_ack_d;
        end
    end

    assign grant_ack = grant_ack_q;
    assign tx_data   = tx_data_q;
    assign tx_start  = (state_q == S_LAUNCH);
    assign rts       = rts_q;
    assign active_id = active_id_q;
    assign busy      = (state_q != S_IDLE);
    assign start_err = start_err_q;
    assign state_dbg = state_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: cycle table for corner cases, fixed fairness
// sequence, then randomized traffic against a round-robin reference model.
module tb_uart_tx_scheduler;
    localparam int NUM_REQ  = 4;
    localparam int DATA_W   = 7;
    localparam int START_TO = 4;
    localparam int GAP      = 2;

    localparam logic [27:0] D  = {7'h33, 7'h22, 7'h11, 7'h55};
    localparam logic [27:0] D2 = {7'h33, 7'h22, 7'h11, 7'h2A};

    logic        baud_clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [27:0] req_data = '0;
    logic [3:0]  grant_ack;
    logic [6:0]  tx_data;
    logic        tx_start;
    logic        tx_buffer_empty;
    logic        cts = 1'b1;
    logic        rts;
    logic [1:0]  active_id;
    logic        busy;
    logic        start_err;
    logic [2:0]  state_dbg;

    logic tbe_tab = 1'b1;
    logic tbe_mod;
    logic model_en = 1'b0;
    assign tx_buffer_empty = model_en ? tbe_mod : tbe_tab;

    int n_vec  = 0;
    int n_fail = 0;

    uart_tx_scheduler #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .START_TO(START_TO), .GAP(GAP)
    ) dut (
        .baud_clk(baud_clk), .rst(rst), .req(req), .req_data(req_data),
        .grant_ack(grant_ack), .tx_data(tx_data), .tx_start(tx_start),
        .tx_buffer_empty(tx_buffer_empty), .cts(cts), .rts(rts),
        .active_id(active_id), .busy(busy), .start_err(start_err),
        .state_dbg(state_dbg)
    );

    // Clock and watchdog
    always #5 baud_clk = ~baud_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Transmitter model: drops buffer-empty one edge after tx_start, frame of 1..5 cycles
    initial begin
        tbe_mod = 1'b1;
        forever begin
            @(negedge baud_clk);
            if (model_en && tx_start) begin
                @(posedge baud_clk);
                #1 tbe_mod = 1'b0;
                repeat ($urandom_range(1, 5)) @(posedge baud_clk);
                #1 tbe_mod = 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic        rst;
        logic [3:0]  req;
        logic        cts;
        logic        tbe;
        logic [27:0] data;
        logic        st;
        logic        busy;
        logic [3:0]  ack;
        logic [1:0]  id;
        logic [6:0]  txd;
        logic        serr;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic r, input logic [3:0] rq, input logic c, input logic tb,
                           input logic [27:0] d, input logic st, input logic bz,
                           input logic [3:0] ak, input logic [1:0] id, input logic [6:0] txd,
                           input logic se);
        vec_t v;
        v = '{rst: r, req: rq, cts: c, tbe: tb, data: d, st: st, busy: bz,
              ack: ak, id: id, txd: txd, serr: se};
        vecs.push_back(v);
    endtask

    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (r[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic do_reset();
        int w;
        w = 0;
        @(negedge baud_clk);
        req = '0;
        cts = 1'b1;
        while (tx_buffer_empty !== 1'b1 && w < 20) begin
            @(negedge baud_clk);
            w++;
        end
        model_en = 1'b0;
        tbe_tab  = 1'b1;
        rst      = 1'b1;
        @(negedge baud_clk);
        @(negedge baud_clk);
        rst = 1'b0;
    endtask

    logic [6:0]  bytes [NUM_REQ][8];
    int          n_bytes [NUM_REQ];
    int          head [NUM_REQ];
    logic [8:0]  exp_q[$];

    task automatic drive_requesters();
        for (int i = 0; i < NUM_REQ; i++) begin
            req[i] = (head[i] < n_bytes[i]);
            req_data[i*DATA_W +: DATA_W] = (head[i] < n_bytes[i]) ? bytes[i][head[i]] : 7'h00;
        end
    endtask

    initial begin
        vec_t v;
        int   order[5];
        int   got_id;
        logic [3:0] got;
        int   waited;
        int   total, acks, cyc, last_ptr, w;
        logic [3:0] prev_req;
        logic [8:0] e;

        // Single request, new request during frame end, reset mid-frame
        add_vec(1, 4'h0, 1, 1, D,  0, 0, 4'h0, 0, 7'h00, 0);
        add_vec(0, 4'h1, 1, 1, D,  1, 1, 4'h0, 0, 7'h55, 0);
        add_vec(0, 4'h1, 1, 1, D2, 0, 1, 4'h0, 0, 7'h55, 0);
        add_vec(0, 4'h1, 1, 0, D2, 0, 1, 4'h1, 0, 7'h55, 0);
        add_vec(0, 4'h0, 1, 0, D,  0, 1, 4'h0, 0, 7'h55, 0);
        add_vec(0, 4'h0, 1, 0, D,  0, 1, 4'h0, 0, 7'h55, 0);
        add_vec(0, 4'h8, 1, 1, D,  0, 1, 4'h0, 0, 7'h55, 0);
        add_vec(0, 4'h8, 1, 1, D,  0, 1, 4'h0, 0, 7'h55, 0);
        add_vec(0, 4'h8, 1, 1, D,  0, 0, 4'h0, 0, 7'h55, 0);
        add_vec(0, 4'h8, 1, 1, D,  1, 1, 4'h0, 3, 7'h33, 0);
        add_vec(0, 4'h8, 1, 1, D,  0, 1, 4'h0, 3, 7'h33, 0);
        add_vec(0, 4'h8, 1, 0, D,  0, 1, 4'h8, 3, 7'h33, 0);
        add_vec(0, 4'h0, 1, 0, D,  0, 1, 4'h0, 3, 7'h33, 0);
        add_vec(1, 4'h0, 1, 0, D,  0, 0, 4'h0, 0, 7'h00, 0);
        add_vec(0, 4'h8, 1, 1, D,  1, 1, 4'h0, 3, 7'h33, 0);
        add_vec(0, 4'h8, 1, 1, D,  0, 1, 4'h0, 3, 7'h33, 0);
        add_vec(0, 4'h8, 1, 0, D,  0, 1, 4'h8, 3, 7'h33, 0);
        add_vec(0, 4'h0, 1, 0, D,  0, 1, 4'h0, 3, 7'h33, 0);
        add_vec(0, 4'h0, 1, 1, D,  0, 1, 4'h0, 3, 7'h33, 0);
        add_vec(0, 4'h0, 1, 1, D,  0, 1, 4'h0, 3, 7'h33, 0);
        add_vec(0, 4'h0, 1, 1, D,  0, 0, 4'h0, 3, 7'h33, 0);
        // Flow control: 20 cycles of cts low, then launch, cts dropped mid-frame
        for (int k = 0; k < 20; k++) add_vec(0, 4'h4, 0, 1, D, 0, 0, 4'h0, 3, 7'h33, 0);
        add_vec(0, 4'h4, 1, 1, D,  1, 1, 4'h0, 2, 7'h22, 0);
        add_vec(0, 4'h4, 0, 1, D,  0, 1, 4'h0, 2, 7'h22, 0);
        add_vec(0, 4'h4, 0, 0, D,  0, 1, 4'h4, 2, 7'h22, 0);
        add_vec(0, 4'h0, 0, 0, D,  0, 1, 4'h0, 2, 7'h22, 0);
        add_vec(0, 4'h0, 0, 1, D,  0, 1, 4'h0, 2, 7'h22, 0);
        add_vec(0, 4'h0, 1, 1, D,  0, 1, 4'h0, 2, 7'h22, 0);
        add_vec(0, 4'h0, 1, 1, D,  0, 0, 4'h0, 2, 7'h22, 0);
        // Start timeout on requester 1, retry must pick 1 again over 2
        add_vec(0, 4'h2, 1, 1, D,  1, 1, 4'h0, 1, 7'h11, 0);
        for (int k = 0; k < START_TO; k++) add_vec(0, 4'h2, 1, 1, D, 0, 1, 4'h0, 1, 7'h11, 0);
        add_vec(0, 4'h2, 1, 1, D,  0, 0, 4'h0, 1, 7'h11, 1);
        add_vec(0, 4'h6, 1, 1, D,  1, 1, 4'h0, 1, 7'h11, 1);
        add_vec(0, 4'h6, 1, 1, D,  0, 1, 4'h0, 1, 7'h11, 1);
        add_vec(0, 4'h6, 1, 0, D,  0, 1, 4'h2, 1, 7'h11, 1);
        add_vec(0, 4'h4, 1, 0, D,  0, 1, 4'h0, 1, 7'h11, 1);
        add_vec(0, 4'h4, 1, 1, D,  0, 1, 4'h0, 1, 7'h11, 1);
        add_vec(0, 4'h4, 1, 1, D,  0, 1, 4'h0, 1, 7'h11, 1);
        add_vec(0, 4'h4, 1, 1, D,  0, 0, 4'h0, 1, 7'h11, 1);
        add_vec(0, 4'h4, 1, 1, D,  1, 1, 4'h0, 2, 7'h22, 1);

        for (int k = 0; k < vecs.size(); k++) begin
            v = vecs[k];
            @(negedge baud_clk);
            rst      = v.rst;
            req      = v.req;
            cts      = v.cts;
            tbe_tab  = v.tbe;
            req_data = v.data;
            @(posedge baud_clk);
            #1;
            check($sformatf("v%0d tx_start", k),  32'(tx_start),  32'(v.st));
            check($sformatf("v%0d busy", k),      32'(busy),      32'(v.busy));
            check($sformatf("v%0d grant_ack", k), 32'(grant_ack), 32'(v.ack));
            check($sformatf("v%0d rts", k),       32'(rts),       32'(v.rst ? 1'b0 : |v.req));
            check($sformatf("v%0d active_id", k), 32'(active_id), 32'(v.id));
            check($sformatf("v%0d tx_data", k),   32'(tx_data),   32'(v.txd));
            check($sformatf("v%0d start_err", k), 32'(start_err), 32'(v.serr));
        end

        // Fairness: all four pending continuously, order 0,1,2,3,0
        do_reset();
        #1;
        check("fair reset start_err", 32'(start_err), 32'd0);
        check("fair reset busy", 32'(busy), 32'd0);
        order = '{0, 1, 2, 3, 0};
        model_en = 1'b1;
        req      = 4'hF;
        req_data = {7'h13, 7'h12, 7'h11, 7'h10};
        for (int f = 0; f < 5; f++) begin
            got    = '0;
            waited = 0;
            while (got == 4'h0 && waited < 60) begin
                @(negedge baud_clk);
                got = grant_ack;
                waited++;
            end
            if (got == 4'h0) begin
                check($sformatf("fair frame %0d ack timeout", f), 32'd0, 32'd1);
            end else begin
                check($sformatf("fair frame %0d grant_ack", f), 32'(got), 32'(4'h1 << order[f]));
                check($sformatf("fair frame %0d active_id", f), 32'(active_id), 32'(order[f]));
                check($sformatf("fair frame %0d tx_data", f), 32'(tx_data), 32'(7'h10 + order[f]));
                @(negedge baud_clk);
                check($sformatf("fair frame %0d ack pulse width", f), 32'(grant_ack), 32'd0);
            end
        end

        // Randomized traffic against the round-robin model
        do_reset();
        total = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            head[i]    = 0;
            n_bytes[i] = $urandom_range(1, 6);
            total     += n_bytes[i];
            for (int j = 0; j < 8; j++) bytes[i][j] = 7'($urandom_range(0, 127));
        end
        model_en = 1'b1;
        acks     = 0;
        cyc      = 0;
        last_ptr = NUM_REQ - 1;
        drive_requesters();
        prev_req = req;
        while (acks < total && cyc < 5000) begin
            @(negedge baud_clk);
            cyc++;
            if (tx_start) begin
                w = rr_pick(prev_req, last_ptr);
                check("rand launch without prior ack", 32'(exp_q.size()), 32'd0);
                if (w < 0) begin
                    check("rand launch with nothing pending", 32'(prev_req), 32'hFFFF_FFFF);
                end else begin
                    check($sformatf("rand launch %0d active_id", acks), 32'(active_id), 32'(w));
                    check($sformatf("rand launch %0d tx_data", acks), 32'(tx_data), 32'(bytes[w][head[w]]));
                    exp_q.push_back({2'(w), bytes[w][head[w]]});
                end
            end
            if (grant_ack != 4'h0) begin
                if (exp_q.size() == 0) begin
                    check("rand ack without launch", 32'(grant_ack), 32'd0);
                end else begin
                    e      = exp_q.pop_front();
                    got_id = int'(e[8:7]);
                    check($sformatf("rand ack %0d grant_ack", acks), 32'(grant_ack), 32'(4'h1 << got_id));
                    check($sformatf("rand ack %0d tx_data", acks), 32'(tx_data), 32'(e[6:0]));
                    head[got_id]++;
                    last_ptr = got_id;
                    acks++;
                end
            end
            cts = ($urandom_range(0, 3) != 0);
            drive_requesters();
            prev_req = req;
        end
        check("rand all bytes acked", 32'(acks), 32'(total));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
